// File: rtl/main_control_pkg.sv
// Shared encodings for the main control FSM: states, opcodes, R-type functions,
// writeback selects and the instruction classification helpers.
package main_control_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH    = 3'd0;
  localparam state_t S_DECODE   = 3'd1;
  localparam state_t S_EXEC     = 3'd2;
  localparam state_t S_WAIT_ALU = 3'd3;
  localparam state_t S_MEM      = 3'd4;
  localparam state_t S_WB       = 3'd5;
  localparam state_t S_WB2      = 3'd6;
  localparam state_t S_TRAP     = 3'd7;

  localparam logic [3:0] OP_IMM_A = 4'b1000;
  localparam logic [3:0] OP_IMM_B = 4'b1001;
  localparam logic [3:0] OP_LBI   = 4'b1010;
  localparam logic [3:0] OP_SBI   = 4'b1011;
  localparam logic [3:0] OP_LD    = 4'b1100;
  localparam logic [3:0] OP_ST    = 4'b1101;
  localparam logic [3:0] OP_RTYPE = 4'b1111;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MUL  = 4'b0010;
  localparam logic [3:0] FN_DIV  = 4'b0011;
  localparam logic [3:0] FN_MOVE = 4'b0100;
  localparam logic [3:0] FN_SWAP = 4'b0101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_SWAP = 2'b10;

  // func is only checked for R-type; for the other opcodes it is an immediate
  function automatic logic is_legal(input logic [3:0] op, input logic [3:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_MOVE, FN_SWAP: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_IMM_A, OP_IMM_B, OP_LBI, OP_SBI, OP_LD, OP_ST: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LBI) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SBI) || (op == OP_ST);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op, input logic [3:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_MUL) || (fn == FN_DIV));
  endfunction

  function automatic logic is_swap(input logic [3:0] op, input logic [3:0] fn);
    return (op == OP_RTYPE) && (fn == FN_SWAP);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake watchdog: counts waiting cycles and flags the last permitted one.
module wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_r;

  // clear has priority so a fresh wait always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // high during the limit-th waiting cycle; the caller lets a handshake win it
  assign expired = (count_r == (limit - 8'd1));

endmodule

// File: rtl/main_control.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and
// writeback strobes with a sticky trap on illegal encodings or handshake timeout.
module main_control
  import main_control_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        alu_done,
  output logic [3:0]  ctrl,
  output logic [3:0]  func,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_imm,
  output logic        alu_start,
  output logic        trap
);

  state_t      state_r, state_next_s;
  logic [15:0] ir_r;
  logic [3:0]  ctrl_r, func_r;
  logic        timer_en_s, timer_clr_s, expired_s;
  logic        ir_write_s, pc_write_s, mem_read_s, mem_write_s, mem_byte_s;
  logic        reg_write_s, alu_src_imm_s, alu_start_s;
  logic [1:0]  wb_sel_s;
  logic        unused_ir_s;

  assign unused_ir_s = ^ir_r[11:4];

  // next state, strobes and watchdog enable
  always_comb begin
    state_next_s  = state_r;
    timer_en_s    = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    mem_byte_s    = 1'b0;
    reg_write_s   = 1'b0;
    wb_sel_s      = WB_ALU;
    alu_src_imm_s = 1'b0;
    alu_start_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else if (expired_s) begin
          state_next_s = S_TRAP;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(ir_r[15:12], ir_r[3:0])) begin
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src_imm_s = (ctrl_r != OP_RTYPE);
        if (is_muldiv(ctrl_r, func_r)) begin
          alu_start_s  = 1'b1;
          state_next_s = S_WAIT_ALU;
        end else if (is_load(ctrl_r) || is_store(ctrl_r)) begin
          state_next_s = S_MEM;
        end else begin
          state_next_s = S_WB;
        end
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          state_next_s = S_WB;
        end else if (expired_s) begin
          state_next_s = S_TRAP;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      S_MEM: begin
        mem_read_s  = is_load(ctrl_r);
        mem_write_s = is_store(ctrl_r);
        mem_byte_s  = (ctrl_r == OP_LBI) || (ctrl_r == OP_SBI);
        if (mem_ready) begin
          state_next_s = is_load(ctrl_r) ? S_WB : S_FETCH;
        end else if (expired_s) begin
          state_next_s = S_TRAP;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        wb_sel_s     = is_load(ctrl_r) ? WB_MEM : WB_ALU;
        state_next_s = is_swap(ctrl_r, func_r) ? S_WB2 : S_FETCH;
      end
      S_WB2: begin
        reg_write_s  = 1'b1;
        wb_sel_s     = WB_SWAP;
        state_next_s = S_FETCH;
      end
      S_TRAP: begin
        state_next_s = S_TRAP;
      end
      default: begin
        state_next_s = S_TRAP;
      end
    endcase
  end

  // every state change starts a fresh wait, which covers entry to FETCH/MEM/WAIT_ALU
  assign timer_clr_s = (state_next_s != state_r);

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clr_s),
    .enable  (timer_en_s),
    .limit   (8'(MAX_WAIT)),
    .expired (expired_s)
  );

  // FSM state, instruction register and the latched ALU control fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      ir_r    <= 16'h0000;
      ctrl_r  <= 4'b0000;
      func_r  <= 4'b0000;
    end else begin
      state_r <= state_next_s;
      if (ir_write_s) begin
        ir_r <= instr;
      end else begin
        ir_r <= ir_r;
      end
      if (state_r == S_DECODE) begin
        ctrl_r <= ir_r[15:12];
        func_r <= ir_r[3:0];
      end else begin
        ctrl_r <= ctrl_r;
        func_r <= func_r;
      end
    end
  end

  // strobes are quenched while reset is held so FETCH only reads once released
  assign ir_write    = ir_write_s    & rst_n;
  assign pc_write    = pc_write_s    & rst_n;
  assign mem_read    = mem_read_s    & rst_n;
  assign mem_write   = mem_write_s   & rst_n;
  assign mem_byte    = mem_byte_s    & rst_n;
  assign reg_write   = reg_write_s   & rst_n;
  assign wb_sel      = wb_sel_s      & {2{rst_n}};
  assign alu_src_imm = alu_src_imm_s & rst_n;
  assign alu_start   = alu_start_s   & rst_n;
  assign ctrl        = ctrl_r;
  assign func        = func_r;
  assign trap        = (state_r == S_TRAP);

endmodule

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 MAX_WAIT, 15, max cycles waiting on mem_ready/alu_done before TRAP (legal 1..255).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  16  fetched word: opcode [15:12], rd [11:8], rs [7:4], func/imm [3:0].
REQ-005 mem_ready  input  1  memory completes current read/write this cycle.
REQ-006 alu_done  input  1  multi-cycle ALU result valid.
REQ-007 ctrl  output  4  latched opcode to ALU control stage.
REQ-008 func  output  4  latched instr[3:0] to ALU control stage.
REQ-009 ir_write  output  1  load instr into IR.
REQ-010 pc_write  output  1  PC increment strobe.
REQ-011 mem_read  output  1  memory read request.
REQ-012 mem_write  output  1  memory write request.
REQ-013 mem_byte  output  1  byte-wide access (LBi/SBi).
REQ-014 reg_write  output  1  register file write strobe.
REQ-015 wb_sel  output  2  writeback source: 00 ALU, 01 MEM, 10 swap-second operand.
REQ-016 alu_src_imm  output  1  ALU B operand = immediate.
REQ-017 alu_start  output  1  one-cycle start pulse for MUL/DIV.
REQ-018 trap  output  1  sticky illegal-instruction/timeout flag.

Function
REQ-019 States SHALL be FETCH, DECODE, EXEC, WAIT_ALU, MEM, WB, WB2, TRAP.
REQ-020 FETCH: mem_read=1; on mem_ready, ir_write=1 and pc_write=1 same cycle -> DECODE; else stay.
REQ-021 DECODE: ctrl/func register from IR, held stable until next DECODE; legal opcodes 1111, 1000-1101; legal R-type func 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 MOVE, 0101 SWAP; anything else -> TRAP, else -> EXEC.
REQ-022 EXEC: alu_src_imm=1 for every opcode except 1111; MUL/DIV: alu_start=1 for exactly one cycle -> WAIT_ALU; 1010/1100 (loads) and 1011/1101 (stores) -> MEM; all others -> WB.
REQ-023 WAIT_ALU: hold until alu_done=1 -> WB; alu_done SHALL be ignored in every other state.
REQ-024 MEM: mem_read=1 for loads, mem_write=1 for stores, mem_byte=1 for 1010/1011; held until mem_ready; loads -> WB, stores -> FETCH.
REQ-025 WB: reg_write=1 one cycle; wb_sel=01 for loads, else 00; SWAP -> WB2, else -> FETCH.
REQ-026 WB2: reg_write=1, wb_sel=10, one cycle -> FETCH.
REQ-027 Wait counter (8-bit) SHALL clear on entry to FETCH, MEM, WAIT_ALU and increment each waiting cycle; reaching MAX_WAIT without handshake -> TRAP; a handshake in the cycle the count reaches MAX_WAIT SHALL win.
REQ-028 TRAP: trap=1, all strobes 0, exit only by reset.
REQ-029 Strobes SHALL be 0 in every state not listed as asserting them; mem_ready outside FETCH/MEM ignored.
REQ-030 Latency with zero-wait handshakes: ALU/immediate ops 4 cycles, stores 4, loads 5, SWAP 5, MUL/DIV 4 + ALU wait.

Reset
REQ-031 rst_n low SHALL immediately force state=FETCH, IR=0, counter=0, ctrl=0000, func=0000, trap=0, all strobes 0, aborting any in-flight operation.
REQ-032 First mem_read SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-033 Package main_control_pkg SHALL hold state enum, opcode constants, R-type func constants, wb_sel codes.
REQ-034 Wait counter SHALL be sub-module wait_timer (clear, enable, limit, expired).

Verification
REQ-035 instr=16'hF120, mem_ready tied 1 -> ctrl=1111, func=0000 after DECODE; reg_write in cycle 4, wb_sel=00; back in FETCH cycle 5.
REQ-036 instr=16'hC123, mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, mem_byte=0, then reg_write with wb_sel=01.
REQ-037 instr=16'hF122, alu_done after 5 cycles -> alu_start exactly one pulse, WB in cycle after alu_done.
REQ-038 instr=16'hF125 -> reg_write two consecutive cycles, wb_sel 00 then 10.
REQ-039 instr=16'h0000 -> trap=1 the cycle after DECODE, sticky; separately mem_ready never asserted -> trap after 15 FETCH cycles.
REQ-040 rst_n pulsed low during MEM of 16'hD123 -> mem_write drops immediately; FETCH resumes with mem_read after release.
